// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer that owns HI/LO for EX.
//   MUL_LAT   : multiply compute cycles after accept (1..15)
//   clk, rst  : clock, synchronous active-high reset
//   start     : HI/LO-class instruction valid in EX (held while stalled)
//   op        : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO (6/7 ignored)
//   src_a/b   : forwarded rs/rt operands
//   flush     : cancel the EX instruction
//   stall     : freeze IF/ID/EX while an operation is running
//   busy      : registered, high in MUL/DIV states
//   hi, lo    : HI/LO registers
module muldiv_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0,
                         S_MUL  = 2'd1,
                         S_DIV  = 2'd2,
                         S_DONE = 2'd3;
  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);

  logic [1:0]  state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] a_mag, b_mag;
  logic        neg_q, neg_r;
  logic [63:0] rq;

  logic        go, accept, is_signed, a_sgn, b_sgn;
  logic [31:0] a_abs, b_abs;
  logic [32:0] div_top;
  logic [33:0] div_diff;
  logic [63:0] rq_step, prod, mul_res;
  logic [31:0] quot, rem;

  assign go        = (state == S_IDLE) & start & ~flush;
  assign accept    = go & ~op[2];
  assign is_signed = (op == 3'd0) | (op == 3'd2);
  assign a_sgn     = is_signed & src_a[31];
  assign b_sgn     = is_signed & src_b[31];
  assign a_abs     = a_sgn ? -src_a : src_a;
  assign b_abs     = b_sgn ? -src_b : src_b;

  // Restoring step: the partial remainder shifted left plus the next dividend
  // bit can reach 33 bits, so the compare is done one bit wider.
  assign div_top  = rq[63:31];
  assign div_diff = {1'b0, div_top} - {2'b00, b_mag};
  assign rq_step  = div_diff[33] ? {div_top[31:0], rq[30:0], 1'b0}
                                 : {div_diff[31:0], rq[30:0], 1'b1};
  assign quot     = rq_step[31:0];
  assign rem      = rq_step[63:32];

  assign prod    = {32'd0, a_mag} * {32'd0, b_mag};
  assign mul_res = neg_q ? -prod : prod;

  assign stall = (((state == S_IDLE) & start & ~op[2]) |
                  (state == S_MUL) | (state == S_DIV)) & ~flush;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = op[1] ? S_DIV : S_MUL;
      S_MUL:  if (flush) state_nxt = S_IDLE;
              else if (cnt == 5'd0) state_nxt = S_DONE;
      S_DIV:  if (flush) state_nxt = S_IDLE;
              else if (cnt == 5'd0) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      busy  <= 1'b0;
      a_mag <= 32'd0;
      b_mag <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rq    <= 64'd0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_MUL) | (state_nxt == S_DIV);
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_mag <= a_abs;
            b_mag <= b_abs;
            neg_q <= a_sgn ^ b_sgn;
            neg_r <= a_sgn;
            rq    <= {32'd0, a_abs};
            cnt   <= op[1] ? 5'd31 : MUL_CNT;
          end else if (go && op == 3'd4) begin
            hi <= src_a;
          end else if (go && op == 3'd5) begin
            lo <= src_a;
          end
        end
        S_MUL: begin
          if (!flush) begin
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) {hi, lo} <= mul_res;
          end
        end
        S_DIV: begin
          if (!flush) begin
            cnt <= cnt - 5'd1;
            rq  <= rq_step;
            if (cnt == 5'd0) begin
              lo <= neg_q ? -quot : quot;
              hi <= neg_r ? -rem : rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall, busy;
  logic [31:0] hi, lo;

  muldiv_ctrl #(.MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a completed (or cancelled) operation shows up as busy falling.
  always @(negedge clk) begin
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: result with empty queue hi=0x%08h lo=0x%08h", hi, lo);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
      end
    end
    prev_busy = busy;
  end

  // Present an op right after a rising edge and count stall cycles up to DONE.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    exp_t e;
    e.name = name; e.hi = eh; e.lo = el;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    sb_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
  endtask

  // Drop start after DONE; a re-accept in DONE would show busy here.
  task automatic end_op(input string name);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({name, "_no_reaccept_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v, input logic fl);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = v; flush = fl;
    @(negedge clk);
    chk("mt_stall", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // MULT -2 * 7 held through DONE
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd7, 4, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
    end_op("mult_neg");

    // MULTU then a DIV presented in the IDLE cycle right after DONE
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 4, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    end_op("div_m7_2");

    // Divide by zero and the overflow case
    run_op("divu_by0", 3'd3, 32'd7, 32'd0, 33, 32'd7, 32'hFFFF_FFFF);
    end_op("divu_by0");
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    end_op("div_ovf");

    // MTHI / MTLO back to back
    mt(3'd4, 32'hDEAD_BEEF, 1'b0);
    mt(3'd5, 32'h1234_5678, 1'b0);
    chk("mthi_visible", hi, 32'hDEAD_BEEF);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("mtlo_visible", lo, 32'h1234_5678);
    chk("mthi_hold", hi, 32'hDEAD_BEEF);

    // MTHI under flush must not write
    mt(3'd4, 32'h0BAD_0BAD, 1'b1);
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("mthi_flush_nowrite", hi, 32'hDEAD_BEEF);

    // Flush in the 10th stall cycle of a divide
    mt(3'd4, 32'h11, 1'b0);
    mt(3'd5, 32'h22, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
    sb_q.push_back('{name: "div_flush", hi: 32'h11, lo: 32'h22});
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall_low", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);
    chk("flush_idle_stall", {31'd0, stall}, 32'd0);

    // Reset for two cycles in the middle of a divide
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; src_a = 32'd12345; src_b = 32'd7;
    sb_q.push_back('{name: "div_rst", hi: 32'd0, lo: 32'd0});
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);

    // Every issued operation must have produced a result event
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer and HI/LO register owner for the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a fixed-latency multiply or a 32-iteration restoring divide. While it runs, it holds the pipeline through `stall`, which the pipeline ORs with the forwarding unit's stall. Results land in HI/LO, which EX reads directly for MFHI/MFLO.

## Interface
- `MUL_LAT`, default 3: multiply compute cycles after accept; legal range 1..15.
- `clk` input 1: clock.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `start` input 1: a valid HI/LO-class instruction is in EX this cycle. Held high while the pipeline is stalled.
- `op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. Values 6 and 7 are ignored.
- `src_a` input 32: rs operand, already forwarded.
- `src_b` input 32: rt operand, already forwarded.
- `flush` input 1: cancels the EX instruction (exception or redirect).
- `stall` output 1: freeze IF/ID/EX; bubble into MM.
- `busy` output 1: state is MUL or DIV.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- **States:** IDLE, MUL, DIV, DONE. A 5-bit counter `cnt` tracks progress.
- **Reset:** state IDLE, `cnt` = 0, `hi` = `lo` = 0, `stall` = 0, `busy` = 0.
- **Accept:** only in IDLE, when `start` & !`flush` & `op` ≤ 3.
  - Latch the operands and sign flags.
  - MULT/MULTU go to MUL with `cnt` = MUL_LAT-1.
  - DIV/DIVU go to DIV with `cnt` = 31.
  - The signed variants work on magnitudes: |a| and |b|.
- **MTHI/MTLO:** in IDLE with `start` & !`flush`, write `src_a` to HI or LO at the clock edge. No stall, no state change.
- **MUL:** decrement `cnt`. When `cnt` = 0, write the 64-bit product {hi,lo} and go to DONE.
  - Signed multiply negates the magnitude product when the operand signs differ.
- **DIV:** one restoring step per cycle on a 64-bit remainder/quotient shift register. When `cnt` = 0, apply sign fix, write lo = quotient and hi = remainder, then go to DONE.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- **DONE:** `stall` = 0, so the pipeline advances. `start` is still high this cycle for the same instruction and must not re-accept. The next state is unconditionally IDLE.
- **stall** = ((state==IDLE & `start` & `op`≤3) | state==MUL | state==DIV) & !`flush`.
- **flush** while in MUL or DIV: next state IDLE. HI/LO stay unchanged; the partial result is discarded. `stall` drops in the same cycle.
- **Divide by zero:** no trap. The natural restoring result is written: quotient 0xFFFFFFFF and remainder = |a|, then sign fix applied.
- **Overflow case** 0x80000000 / 0xFFFFFFFF (DIV): lo = 0x80000000, hi = 0. Arithmetic wraps mod 2^32.
- **`rst` mid-operation:** same effect as reset, including clearing HI/LO.

## Timing
- **Multiply:** accept cycle plus MUL_LAT compute cycles, so `stall` is high for MUL_LAT+1 cycles. DONE follows, with the new HI/LO visible on outputs in the DONE cycle.
- **Divide:** `stall` is high for 33 cycles (accept + 32). Results are visible in the DONE cycle.
- **Back-to-back HI/LO instructions:** the earliest possible next accept is the cycle after DONE (IDLE).
  - MFHI/MFLO issued right after reads the final HI/LO.
  - MTHI/MTLO write at the edge ending their IDLE cycle, so they are visible the next cycle.
- **Outputs:** `busy`, `hi` and `lo` are registered. `stall` is combinational from state, `start`, `op` and `flush`.
- **flush with start in IDLE:** `flush` wins. Nothing is accepted and MT* does not write.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-divide → hi=lo=0, `stall`=0, `busy`=0, state IDLE on the first cycle after release.
- **MULT, MUL_LAT=3:** `src_a`=0xFFFFFFFE (-2), `src_b`=7 → `stall` high exactly 4 cycles, then DONE with hi=0xFFFFFFFF, lo=0xFFFFFFF2. A second MULTU 0xFFFFFFFF×2 gives hi=1, lo=0xFFFFFFFE.
- **DIV:** -7/2 → `stall` 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → lo=0xFFFFFFFF, hi=7. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- **Flush:** assert `flush` on cycle 10 of a DIV with hi=0x11, lo=0x22 beforehand → `stall` low that same cycle, IDLE next cycle, hi=0x11 and lo=0x22 unchanged.
- **MT*:** MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles → no stall, hi and lo read back the values the following cycles. MTHI with `flush` high → no write.
- **DONE handling:** hold `start`+MULT through DONE → no re-accept; `stall`=0 in DONE. A new DIV presented the next cycle is accepted.
